// File: rtl/switch_pattern_gen.sv
// Drives sw3/sw2/sw1 toward a requested chain entry one legal step at a time,
// so the downstream switch decoder only ever sees legal single-bit transitions.
module switch_pattern_gen #(
    parameter int unsigned STEP_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_n3,
    input  logic [31:0] req_n2,
    input  logic [31:0] req_n1,
    output logic        sw3,
    output logic        sw2,
    output logic        sw1,
    output logic [2:0]  pos,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_MOVE  = 2'd2
    } state_e;

    localparam logic [7:0] RELOAD = 8'(STEP_DIV - 32'd1);

    // Chain index to switch pattern {sw3, sw2, sw1}
    function automatic logic [2:0] chain_pat(input logic [2:0] idx);
        logic [2:0] pat;
        case (idx)
            3'd0:    pat = 3'b000;
            3'd1:    pat = 3'b100;
            3'd2:    pat = 3'b110;
            3'd3:    pat = 3'b111;
            3'd4:    pat = 3'b011;
            default: pat = 3'b000;
        endcase
        return pat;
    endfunction

    // Switch pattern to {legal, chain index}
    function automatic logic [3:0] pat_to_idx(input logic [2:0] pat);
        logic [3:0] res;
        case (pat)
            3'b000:  res = {1'b1, 3'd0};
            3'b100:  res = {1'b1, 3'd1};
            3'b110:  res = {1'b1, 3'd2};
            3'b111:  res = {1'b1, 3'd3};
            3'b011:  res = {1'b1, 3'd4};
            default: res = {1'b0, 3'd0};
        endcase
        return res;
    endfunction

    state_e      state_q, state_d;
    logic [31:0] n3_q, n3_d, n2_q, n2_d, n1_q, n1_d;
    logic [2:0]  pos_q, pos_d;
    logic [2:0]  sw_q, sw_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        req_ready_s;
    logic        in_set_s;
    logic [2:0]  pat_s;
    logic        tgt_ok_s;
    logic [2:0]  tgt_idx_s;
    logic [2:0]  next_pos_s;

    assign req_ready_s = (state_q == ST_IDLE);
    assign in_set_s    = ((n3_q == 32'd0) || (n3_q == 32'd3)) &&
                         ((n2_q == 32'd0) || (n2_q == 32'd2)) &&
                         ((n1_q == 32'd0) || (n1_q == 32'd1));
    assign pat_s       = {(n3_q != 32'd0), (n2_q != 32'd0), (n1_q != 32'd0)};
    assign {tgt_ok_s, tgt_idx_s} = pat_to_idx(pat_s);
    // The chain is linear, so the only path is toward the target index
    assign next_pos_s  = (tgt_idx_s > pos_q) ? (pos_q + 3'd1) : (pos_q - 3'd1);

    // Next-state, held request, step timing and status pulses
    always_comb begin
        state_d = state_q;
        n3_d    = n3_q;
        n2_d    = n2_q;
        n1_d    = n1_q;
        pos_d   = pos_q;
        sw_d    = sw_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_s) begin
                    n3_d    = req_n3;
                    n2_d    = req_n2;
                    n1_d    = req_n1;
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (!(in_set_s && tgt_ok_s)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (tgt_idx_s == pos_q) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = RELOAD;
                    state_d = ST_MOVE;
                end
            end
            ST_MOVE: begin
                if (cnt_q == 8'd0) begin
                    pos_d = next_pos_s;
                    sw_d  = chain_pat(next_pos_s);
                    if (next_pos_s == tgt_idx_s) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = RELOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; rst overrides any pending step or pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            n3_q    <= 32'd0;
            n2_q    <= 32'd0;
            n1_q    <= 32'd0;
            pos_q   <= 3'd0;
            sw_q    <= 3'b000;
            cnt_q   <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n3_q    <= n3_d;
            n2_q    <= n2_d;
            n1_q    <= n1_d;
            pos_q   <= pos_d;
            sw_q    <= sw_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = req_ready_s;
    assign sw3       = sw_q[2];
    assign sw2       = sw_q[1];
    assign sw1       = sw_q[0];
    assign pos       = pos_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_switch_pattern_gen.sv
// Self-checking bench for switch_pattern_gen: directed cases from the test plan
// followed by randomized requests, compared cycle by cycle to an arithmetic model.
module tb_switch_pattern_gen;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_n3, req_n2, req_n1;
    logic        sw3, sw2, sw1;
    logic [2:0]  pos;
    logic        busy, done, err;

    int n_checks = 0;
    int n_fail   = 0;
    int model_pos = 0;

    logic [2:0] chain_tbl [5] = '{3'b000, 3'b100, 3'b110, 3'b111, 3'b011};

    switch_pattern_gen #(.STEP_DIV(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_n3    (req_n3),
        .req_n2    (req_n2),
        .req_n1    (req_n1),
        .sw3       (sw3),
        .sw2       (sw2),
        .sw1       (sw1),
        .pos       (pos),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%03h expected=%03h ({sw,pos,busy,done,err,ready})",
                     tag, $time, got, exp);
        end
    endtask

    // Target chain index of a request, or -1 when it must be rejected
    function automatic int tgt_of(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        logic [2:0] pat;
        if (!((a == 32'd0 || a == 32'd3) && (b == 32'd0 || b == 32'd2) && (c == 32'd0 || c == 32'd1)))
            return -1;
        pat = {a != 32'd0, b != 32'd0, c != 32'd0};
        for (int i = 0; i < 5; i++)
            if (chain_tbl[i] == pat) return i;
        return -1;
    endfunction

    function automatic logic [31:0] vec(input int p, input bit b, input bit d, input bit e, input bit r);
        return {22'd0, chain_tbl[p], 3'(p), b, d, e, r};
    endfunction

    function automatic logic [31:0] obs();
        return {22'd0, sw3, sw2, sw1, pos, busy, done, err, req_ready};
    endfunction

    function automatic logic [31:0] rnd_val(input logic [31:0] w);
        int r;
        r = $urandom_range(0, 9);
        if (r < 4) return 32'd0;
        if (r < 8) return w;
        return $urandom;
    endfunction

    // One request; poke pulses req_valid during the move; rst_at (>0) resets before that edge
    task automatic run_req(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                           input bit poke, input int rst_at);
        int t, p, d, dir, len, k;
        bit fin;
        t = tgt_of(a, b, c);
        p = model_pos;
        d = 0;
        dir = 0;
        if (t < 0) len = 1;
        else begin
            d   = (t > p) ? (t - p) : (p - t);
            dir = (t > p) ? 1 : -1;
            len = (d == 0) ? 1 : 1 + d * S;
        end
        @(negedge clk);
        req_valid = 1'b1;
        req_n3 = a;
        req_n2 = b;
        req_n1 = c;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_n3 = $urandom;
        req_n2 = $urandom;
        req_n1 = $urandom;
        check_eq("accept", obs(), vec(p, 1'b1, 1'b0, 1'b0, 1'b0));
        for (int cc = 1; cc <= len; cc++) begin
            if (poke && len > 3 && cc == 2) begin
                req_valid = 1'b1;
                req_n3 = 32'd3 * 32'($urandom_range(0, 1));
                req_n2 = 32'd2 * 32'($urandom_range(0, 1));
                req_n1 = 32'($urandom_range(0, 1));
            end
            if (poke && len > 3 && cc == 3) req_valid = 1'b0;
            if (rst_at == cc) rst = 1'b1;
            @(posedge clk);
            #1;
            if (rst_at == cc) begin
                check_eq("rst_edge1", obs(), vec(0, 1'b0, 1'b0, 1'b0, 1'b1));
                @(posedge clk);
                #1;
                check_eq("rst_edge2", obs(), vec(0, 1'b0, 1'b0, 1'b0, 1'b1));
                rst = 1'b0;
                model_pos = 0;
                return;
            end
            if (t < 0) check_eq("reject", obs(), vec(p, 1'b0, 1'b0, 1'b1, 1'b1));
            else if (d == 0) check_eq("same_tgt", obs(), vec(p, 1'b0, 1'b1, 1'b0, 1'b1));
            else begin
                k = (cc - 1) / S;
                if (k > d) k = d;
                fin = (cc == len);
                check_eq(fin ? "move_done" : "move", obs(), vec(p + dir * k, !fin, fin, 1'b0, fin));
            end
        end
        if (t >= 0) model_pos = t;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_n3    = 32'd0;
        req_n2    = 32'd0;
        req_n1    = 32'd0;
        @(posedge clk);
        #1;
        check_eq("reset1", obs(), vec(0, 1'b0, 1'b0, 1'b0, 1'b1));
        @(posedge clk);
        #1;
        check_eq("reset2", obs(), vec(0, 1'b0, 1'b0, 1'b0, 1'b1));
        rst = 1'b0;

        run_req(32'd3, 32'd2, 32'd1, 1'b0, 0);   // forward 000 -> 111
        run_req(32'd0, 32'd2, 32'd1, 1'b0, 0);   // 111 -> 011
        run_req(32'd0, 32'd0, 32'd0, 1'b0, 0);   // reverse 011 -> 000
        run_req(32'd0, 32'd2, 32'd0, 1'b0, 0);   // illegal pattern
        run_req(32'd4, 32'd4, 32'd4, 1'b0, 0);   // out-of-set values
        run_req(32'd3, 32'd0, 32'd7, 1'b0, 0);
        run_req(32'd3, 32'd2, 32'd0, 1'b0, 0);   // 000 -> 110
        run_req(32'd3, 32'd2, 32'd0, 1'b0, 0);   // already there
        run_req(32'd0, 32'd0, 32'd0, 1'b1, 0);   // ignored request mid-move
        run_req(32'd3, 32'd2, 32'd1, 1'b0, 2 + 2 * S);  // reset while at pos 2
        run_req(32'd3, 32'd0, 32'd0, 1'b0, 1 + S);      // reset on the done edge
        run_req(32'd0, 32'd2, 32'd1, 1'b0, 0);   // fresh request after reset

        for (int i = 0; i < 40; i++) begin
            run_req(rnd_val(32'd3), rnd_val(32'd2), rnd_val(32'd1),
                    1'($urandom_range(0, 1)), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
